shake_absorb_padder: RTL and testbench

SHAKE_ABSORB_PADDER -- requirements
Module: shake_absorb_padder

---
 rtl/shake_absorb_padder_pkg.sv | 20 ++
 rtl/pad_word_gen.sv | 27 ++
 rtl/shake_absorb_padder.sv | 120 ++++++++++++
 tb/tb_shake_absorb_padder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/shake_absorb_padder_pkg.sv
// Shared constants and types for the SHAKE absorb-side padder.
package shake_absorb_padder_pkg;

    localparam int unsigned WORD_W         = 64;
    localparam int unsigned RATE_W_128_DEF = 21;   // SHAKE128: 1344-bit rate
    localparam int unsigned RATE_W_256_DEF = 17;   // SHAKE256: 1088-bit rate
    localparam int unsigned SLOTS          = RATE_W_128_DEF;
    localparam int unsigned BLOCK_W        = WORD_W * SLOTS;

    localparam logic       MODE_G      = 1'b0;
    localparam logic       MODE_H      = 1'b1;
    localparam logic [7:0] DOMAIN_BYTE = 8'h1F;
    localparam logic [7:0] FINAL_BYTE  = 8'h80;

    typedef enum logic [0:0] {
        StFill,
        StFull
    } state_e;

endpackage

// File: rtl/pad_word_gen.sv
// Byte-lane padding of one message word: keeps the valid bytes of a final
// word, inserts the domain byte right after them and zeroes the rest.
module pad_word_gen
    import shake_absorb_padder_pkg::*;
(
    input  logic [63:0] word,
    input  logic [2:0]  byte_num,
    input  logic        is_last,
    output logic [63:0] padded
);

    logic [7:0] keep_mask;

    // A non-final word passes through untouched; a final word keeps byte_num bytes.
    always_comb begin
        keep_mask = is_last ? (8'hFF >> (4'd8 - {1'b0, byte_num})) : 8'hFF;
        padded    = '0;
        for (int i = 0; i < 8; i++) begin
            if (keep_mask[i]) begin
                padded[8*i +: 8] = word[8*i +: 8];
            end else if (is_last && (3'(i) == byte_num)) begin
                padded[8*i +: 8] = DOMAIN_BYTE;
            end
        end
    end

endmodule

// File: rtl/shake_absorb_padder.sv
// Collects 64-bit message words into a SHAKE128/256 rate block, applies the
// SHAKE padding on the final word and hands the block to the permutation.
module shake_absorb_padder
    import shake_absorb_padder_pkg::*;
#(
    parameter int unsigned RATE_W_128 = RATE_W_128_DEF,
    parameter int unsigned RATE_W_256 = RATE_W_256_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [63:0]        in,
    input  logic               in_ready,
    input  logic               is_last,
    input  logic [2:0]         byte_num,
    input  logic               mode,
    input  logic               f_ack,
    output logic               buffer_full,
    output logic               buffer_last,
    output logic [BLOCK_W-1:0] out,
    output logic               out_ready
);

    state_e             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic               mode_q, mode_d;
    logic               active_q, active_d;   // inside a message; mode already latched
    logic               last_q, last_d;
    logic [BLOCK_W-1:0] blk_q, blk_d;

    logic               eff_mode;
    logic [4:0]         rw;
    logic [63:0]        padded;

    // The first word of a message sees the live mode; later words the latched one.
    assign eff_mode = active_q ? mode_q : mode;
    assign rw       = (eff_mode == MODE_H) ? 5'(RATE_W_256) : 5'(RATE_W_128);

    pad_word_gen u_pad_word_gen (
        .word     (in),
        .byte_num (byte_num),
        .is_last  (is_last),
        .padded   (padded)
    );

    // Next-state: word insertion, final-bit OR and block hand-off.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        active_d = active_q;
        last_d   = last_q;
        blk_d    = blk_q;
        unique case (state_q)
            StFill: begin
                if (in_ready) begin
                    mode_d = eff_mode;
                    for (int k = 0; k < SLOTS; k++) begin
                        if (5'(k) == cnt_q) begin
                            blk_d[WORD_W*k +: WORD_W] = padded;
                        end
                    end
                    if (is_last) begin
                        // Final bit sits in the top byte of the last rate word.
                        for (int k = 0; k < SLOTS; k++) begin
                            if (5'(k) == (rw - 5'd1)) begin
                                blk_d[WORD_W*k+56 +: 8] = blk_d[WORD_W*k+56 +: 8] | FINAL_BYTE;
                            end
                        end
                        state_d  = StFull;
                        last_d   = 1'b1;
                        active_d = 1'b0;
                    end else begin
                        active_d = 1'b1;
                        cnt_d    = cnt_q + 5'd1;
                        if (cnt_q == (rw - 5'd1)) begin
                            state_d = StFull;
                        end
                    end
                end
            end
            StFull: begin
                if (f_ack) begin
                    state_d = StFill;
                    cnt_d   = '0;
                    last_d  = 1'b0;
                    blk_d   = '0;
                end
            end
            default: state_d = StFill;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StFill;
            cnt_q    <= '0;
            mode_q   <= MODE_G;
            active_q <= 1'b0;
            last_q   <= 1'b0;
            blk_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            active_q <= active_d;
            last_q   <= last_d;
            blk_q    <= blk_d;
        end
    end

    // Outputs are driven straight from state so they stay stable while held.
    always_comb begin
        buffer_full = (state_q == StFull);
        out_ready   = (state_q == StFull);
        buffer_last = last_q;
        out         = blk_q;
    end

endmodule

// File: tb/tb_shake_absorb_padder.sv
// Self-checking bench for shake_absorb_padder: directed table plus random
// messages checked against a byte-stream SHAKE padding model.
module tb_shake_absorb_padder;

    localparam int RW_G = 21;
    localparam int RW_H = 17;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [63:0]   in = '0;
    logic          in_ready = 1'b0;
    logic          is_last = 1'b0;
    logic [2:0]    byte_num = '0;
    logic          mode = 1'b0;
    logic          f_ack = 1'b0;
    logic          buffer_full;
    logic          buffer_last;
    logic [1343:0] out;
    logic          out_ready;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0]   msg [64];
    logic [1343:0] exp_q [$];
    logic [1343:0] last_blk;
    int            blocks_seen;

    shake_absorb_padder dut (
        .clk         (clk),
        .reset       (reset),
        .in          (in),
        .in_ready    (in_ready),
        .is_last     (is_last),
        .byte_num    (byte_num),
        .mode        (mode),
        .f_ack       (f_ack),
        .buffer_full (buffer_full),
        .buffer_last (buffer_last),
        .out         (out),
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_blk(input string name, input logic [1343:0] act, input logic [1343:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference: message as a byte stream, append 0x1F, zero-fill to the rate,
    // OR 0x80 into the last byte, split into rate-sized blocks.
    function automatic void build_expected(input logic m, input int n, input int b);
        logic [7:0]    stream [$];
        logic [1343:0] blk;
        int            r;
        r = m ? 8 * RW_H : 8 * RW_G;
        exp_q.delete();
        for (int i = 0; i < n - 1; i++)
            for (int j = 0; j < 8; j++) stream.push_back(msg[i][8*j +: 8]);
        for (int j = 0; j < b; j++) stream.push_back(msg[n-1][8*j +: 8]);
        stream.push_back(8'h1F);
        while ((stream.size() % r) != 0) stream.push_back(8'h00);
        stream[stream.size()-1] = stream[stream.size()-1] | 8'h80;
        for (int k = 0; k < stream.size() / r; k++) begin
            blk = '0;
            for (int j = 0; j < r; j++) blk[8*j +: 8] = stream[k*r + j];
            exp_q.push_back(blk);
        end
    endfunction

    // Drives msg[0..n-1] with random idle gaps, checks every presented block.
    task automatic send_msg(input logic m, input int n, input int b, input int toggle_at,
                            input bit hold);
        int  i = 0;
        int  guard = 0;
        int  rw;
        bit  expect_full = 1'b0;
        bit  word_sent = 1'b0;
        logic [1343:0] saved;
        rw = m ? RW_H : RW_G;
        build_expected(m, n, b);
        blocks_seen = 0;
        while ((i < n || blocks_seen < exp_q.size()) && guard < 4000) begin
            @(negedge clk);
            guard++;
            in_ready = 1'b0;
            f_ack    = 1'b0;
            if (word_sent) begin
                check("full_timing", 64'(buffer_full), 64'(expect_full));
                word_sent = 1'b0;
            end
            if (buffer_full) begin
                if (blocks_seen < exp_q.size()) begin
                    check_blk("block", out, exp_q[blocks_seen]);
                    check("buffer_last", 64'(buffer_last), 64'(blocks_seen == exp_q.size() - 1));
                    check("out_ready", 64'(out_ready), 64'd1);
                end else begin
                    check("extra_block", 64'(buffer_full), 64'd0);
                end
                last_blk = out;
                saved    = out;
                if (hold) begin
                    in_ready = 1'b1;
                    in       = {$urandom(), $urandom()};
                    is_last  = 1'($urandom());
                    repeat (5) @(negedge clk);
                    check_blk("hold_out", out, saved);
                    check("hold_full", 64'(buffer_full), 64'd1);
                    in_ready = 1'b0;
                end
                f_ack = 1'b1;
                @(negedge clk);
                f_ack = 1'b0;
                check("ack_clear", {61'd0, buffer_full, out_ready, buffer_last}, 64'd0);
                check("ack_out_zero", 64'(out == '0), 64'd1);
                blocks_seen++;
            end else if (i < n) begin
                if ($urandom_range(0, 3) == 0) begin
                    f_ack = 1'($urandom());   // must be ignored while filling
                end else begin
                    in_ready = 1'b1;
                    in       = msg[i];
                    is_last  = (i == n - 1);
                    byte_num = (i == n - 1) ? 3'(b) : 3'($urandom());
                    mode     = (toggle_at >= 0 && i >= toggle_at) ? ~m : m;
                    expect_full = (i == n - 1) || (((i + 1) % rw) == 0);
                    word_sent = 1'b1;
                    i++;
                end
            end
        end
        if (guard >= 4000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: got %0d blocks want %0d", blocks_seen, exp_q.size());
        end
        in_ready = 1'b0;
        f_ack    = 1'b0;
    endtask

    typedef struct {
        logic        m;
        int          n;
        int          b;
        logic [63:0] pat;
        int          toggle;
        bit          hold;
        int          exp_blocks;
        int          chk_idx;
        logic [7:0]  chk_val;
        int          fin_idx;
        logic [7:0]  fin_val;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{1'b1,  3, 0, 64'h1111111111111111, -1, 1'b0, 1,  16, 8'h1F, 135, 8'h80};
        vecs[1] = '{1'b1, 17, 7, 64'h00AAAAAAAAAAAAAA, -1, 1'b0, 1, 128, 8'hAA, 135, 8'h9F};
        vecs[2] = '{1'b0, 21, 7, 64'h00BBBBBBBBBBBBBB, -1, 1'b1, 1, 160, 8'hBB, 167, 8'h9F};
        vecs[3] = '{1'b0, 22, 0, 64'h5555555555555555, -1, 1'b0, 2,   0, 8'h1F, 167, 8'h80};
        vecs[4] = '{1'b0,  1, 3, 64'h0123456789ABCDEF, -1, 1'b0, 1,   2, 8'hAB, 167, 8'h80};
        vecs[5] = '{1'b1, 18, 5, 64'hFFFFFFFFFFFFFFFF, -1, 1'b1, 2,   5, 8'h1F, 135, 8'h80};
        vecs[6] = '{1'b0,  6, 2, 64'h7777777777777777,  3, 1'b0, 1,  42, 8'h1F, 167, 8'h80};

        #1;
        check("rst_outputs", {61'd0, buffer_full, out_ready, buffer_last}, 64'd0);
        check("rst_out", 64'(out == '0), 64'd1);
        @(negedge clk);
        reset = 1'b1;

        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < vecs[v].n; i++) msg[i] = vecs[v].pat;
            send_msg(vecs[v].m, vecs[v].n, vecs[v].b, vecs[v].toggle, vecs[v].hold);
            check("vec_blocks", 64'(blocks_seen), 64'(vecs[v].exp_blocks));
            check("vec_chk_byte", 64'(last_blk[8*vecs[v].chk_idx +: 8]), 64'(vecs[v].chk_val));
            check("vec_fin_byte", 64'(last_blk[8*vecs[v].fin_idx +: 8]), 64'(vecs[v].fin_val));
        end

        // Reset in the middle of a block discards the partial words.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_ready = 1'b1;
            in       = {$urandom(), $urandom()};
            is_last  = 1'b0;
            mode     = 1'b0;
        end
        @(negedge clk);
        in_ready = 1'b0;
        reset    = 1'b0;
        #1;
        check("midrst_outputs", {61'd0, buffer_full, out_ready, buffer_last}, 64'd0);
        check("midrst_out", 64'(out == '0), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("postrst_idle", {61'd0, buffer_full, out_ready, buffer_last}, 64'd0);
        for (int i = 0; i < 22; i++) msg[i] = {$urandom(), $urandom()};
        send_msg(1'b0, 22, 0, -1, 1'b0);
        check("postrst_blocks", 64'(blocks_seen), 64'd2);

        // Random messages against the padding model.
        for (int t = 0; t < 12; t++) begin
            int n;
            n = $urandom_range(1, 45);
            for (int i = 0; i < n; i++) msg[i] = {$urandom(), $urandom()};
            send_msg(1'($urandom()), n, $urandom_range(0, 7),
                     ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : -1,
                     1'($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
